// File: rtl/data_mem_responder.sv
// Byte-wide load/store responder: accepts one LB/SB request, waits LATENCY cycles,
// performs the byte access and pulses done (and err for illegal or out-of-range requests).
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     addr_q;
  logic [7:0]      byte_q;
  logic            rd_q;
  logic            wr_q;
  logic [7:0]      mem [Depth];

  logic       in_range;
  logic       illegal;
  logic       access_edge;
  logic       do_write;
  logic [7:0] rd_byte;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  always_comb begin
    in_range    = (addr_q >> ADDR_W) == 32'd0;
    illegal     = rd_q & wr_q;
    access_edge = (state_q == StWait) && (cnt_q == '0);
    do_write    = access_edge && wr_q && !rd_q && in_range;
    rd_byte     = mem[addr_q[ADDR_W-1:0]];
  end

  // Array is intentionally not reset; reset only suppresses a write on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[addr_q[ADDR_W-1:0]] <= byte_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_read || mem_write) begin
            addr_q  <= addr;
            byte_q  <= wdata[7:0];
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            cnt_q   <= CntInit;
            busy    <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            state_q <= StDone;
            done    <= 1'b1;
            err     <= illegal || !in_range;
            if (rd_q && !wr_q) begin
              rdata <= in_range ? {{24{rd_byte[7]}}, rd_byte} : 32'd0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: timeline-based transaction model checked every cycle,
// directed literal cases, latency checks at LATENCY=1/4, then randomized traffic.
module tb_data_mem_responder;

  localparam int unsigned Lat  = 2;
  localparam int unsigned Size = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, err;

  logic        st_s = 1'b0;
  logic [31:0] rdata1, rdata4;
  logic        busy1, done1, err1, busy4, done4, err4;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .LATENCY(Lat)) u_dut (
    .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(1'b0), .mem_write(st_s), .addr(32'h5),
    .wdata(32'h11), .rdata(rdata1), .busy(busy1), .done(done1), .err(err1)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .mem_read(1'b0), .mem_write(st_s), .addr(32'h5),
    .wdata(32'h22), .rdata(rdata4), .busy(busy4), .done(done4), .err(err4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request accepted at edge c completes at c+Lat, retires at c+Lat+1.
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          pend = 0;
  bit          p_rd, p_wr;
  logic [31:0] p_addr;
  logic [7:0]  p_byte;
  logic [7:0]  m_mem [Size];
  logic [31:0] m_rdata = '0;
  bit          m_busy = 0, m_done = 0, m_err = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend = 0; m_busy = 0; m_done = 0; m_err = 0; m_rdata = '0;
    end else if (pend) begin
      if (cyc == acc_cyc + int'(Lat)) begin
        m_done = 1;
        m_err  = (p_rd && p_wr) || (p_addr >= Size);
        if (!(p_rd && p_wr)) begin
          if (p_addr >= Size) begin
            if (p_rd) m_rdata = '0;
          end else if (p_rd) begin
            m_rdata = 32'(m_mem[p_addr % Size]);
            if (m_rdata >= 32'd128) m_rdata = m_rdata + 32'hFFFF_FF00;
          end else begin
            m_mem[p_addr % Size] = p_byte;
          end
        end
      end else if (cyc == acc_cyc + int'(Lat) + 1) begin
        pend = 0; m_busy = 0; m_done = 0; m_err = 0;
      end
    end else if (rd || wr) begin
      pend = 1; acc_cyc = cyc; p_rd = rd; p_wr = wr;
      p_addr = addr; p_byte = wdata[7:0]; m_busy = 1;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_err", 32'(err), 32'(m_err));
      chk("cyc_rdata", rdata, m_rdata);
    end
  end

  task automatic do_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int bcnt, output logic e,
                        output logic [31:0] rdo);
    lat = -1; bcnt = 0; e = 1'bx; rdo = 'x;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k; e = err; rdo = rdata; rd = 1'b0; wr = 1'b0;
      end
    end
    if (lat < 0) begin
      chk("done_timeout", 32'(lat), 32'(Lat));
      rd = 1'b0; wr = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (busy) bcnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          lat, bcnt, l1, l4;
    logic        e;
    logic [31:0] rdo;

    // Reset with random inputs; strobe high on the last reset edge must not be accepted.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rd = 1'($urandom); wr = 1'($urandom); addr = $urandom; wdata = $urandom;
      if (i == 1) rd = 1'b1;
      if (i == 1) chk_en = 1;
    end
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", 32'(busy), 32'h0);

    do_req(0, 1, 32'h10, 32'hABCD12F3, lat, bcnt, e, rdo);
    chk("sb10_lat", 32'(lat), 32'd2);
    chk("sb10_busy_cycles", 32'(bcnt), 32'd3);
    chk("sb10_err", 32'(e), 32'h0);
    do_req(1, 0, 32'h10, 32'h0, lat, bcnt, e, rdo);
    chk("lb10_rdata", rdo, 32'hFFFF_FFF3);

    do_req(0, 1, 32'h20, 32'h7F, lat, bcnt, e, rdo);
    do_req(1, 0, 32'h20, 32'h0, lat, bcnt, e, rdo);
    chk("lb20_rdata", rdo, 32'h0000_007F);

    do_req(1, 0, 32'h100, 32'h0, lat, bcnt, e, rdo);
    chk("lb100_err", 32'(e), 32'h1);
    chk("lb100_rdata", rdo, 32'h0);
    do_req(0, 1, 32'h110, 32'h55, lat, bcnt, e, rdo);
    chk("sb110_err", 32'(e), 32'h1);
    do_req(1, 0, 32'h10, 32'h0, lat, bcnt, e, rdo);
    chk("lb10_after_oob", rdo, 32'hFFFF_FFF3);

    do_req(1, 0, 32'h20, 32'h0, lat, bcnt, e, rdo);
    do_req(1, 1, 32'h10, 32'h66, lat, bcnt, e, rdo);
    chk("both_err", 32'(e), 32'h1);
    chk("both_rdata", rdo, 32'h0000_007F);
    do_req(1, 0, 32'h10, 32'h0, lat, bcnt, e, rdo);
    chk("lb10_after_both", rdo, 32'hFFFF_FFF3);

    // Busy ignore: a store strobe at a new address during WAIT must not disturb the load.
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = 32'h20;
    @(negedge clk);
    addr = 32'h10; wr = 1'b1; wdata = 32'h99;
    @(negedge clk);
    wr = 1'b0;
    for (int k = 0; k < 10 && !done; k++) @(negedge clk);
    chk("ignore_done", 32'(done), 32'h1);
    chk("ignore_rdata", rdata, 32'h0000_007F);
    rd = 1'b0;
    do_req(1, 0, 32'h10, 32'h0, lat, bcnt, e, rdo);
    chk("ignore_mem10", rdo, 32'hFFFF_FFF3);

    // Abort in WAIT, then reset coinciding with the write edge.
    do_req(0, 1, 32'h30, 32'h5A, lat, bcnt, e, rdo);
    @(negedge clk);
    wr = 1'b1; addr = 32'h30; wdata = 32'h01;
    @(negedge clk);
    wr = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    @(negedge clk);
    wr = 1'b1; addr = 32'h30; wdata = 32'h02;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_req(1, 0, 32'h30, 32'h0, lat, bcnt, e, rdo);
    chk("abort_mem30", rdo, 32'h0000_005A);

    // Latency 1 and 4 instances.
    l1 = -1; l4 = -1;
    @(negedge clk);
    st_s = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) st_s = 1'b0;
      if (done1 && l1 < 0) l1 = k;
      if (done4 && l4 < 0) l4 = k;
    end
    chk("lat1_done_edge", 32'(l1), 32'd1);
    chk("lat4_done_edge", 32'(l4), 32'd4);

    // Random traffic over a fully initialised memory.
    for (int i = 0; i < int'(Size); i++) do_req(0, 1, 32'(i), $urandom, lat, bcnt, e, rdo);
    for (int i = 0; i < 150; i++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 7);
      a  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 255));
      do_req(op inside {[0:3]}, op inside {[4:6]} || op == 7, a, $urandom, lat, bcnt, e, rdo);
      chk("rand_lat", 32'(lat), 32'(Lat));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
